// File: rtl/psg_reg_file.sv
// psg_reg_file: SN76489-compatible PSG register file for the SMS sound path.
// Z80 port-0x7F bytes are queued in a small write FIFO. They are then decoded
// through the latch/data protocol into three tone periods, four attenuations
// and the noise control. A pacing gap after each tone update keeps the
// synthesiser dividers from seeing a new period while they are still busy.
// Optional feature: define PSG_READBACK_EN to add the rd_addr/rd_data readback port.
module psg_reg_file #(
    parameter int FIFO_DEPTH = 4,
    parameter int UPDATE_GAP = 20
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_valid,
    input  logic [7:0]      wr_data,
    output logic            wr_ready,
    output logic [2:0][9:0] tone_freq,
    output logic [2:0]      tone_update,
    output logic [3:0][3:0] atten,
    output logic [2:0]      noise_ctrl,
    output logic            noise_reset,
    output logic [2:0]      latch_reg,
    output logic            busy
`ifdef PSG_READBACK_EN
    ,
    input  logic [2:0]      rd_addr,
    output logic [9:0]      rd_data
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int GAP_W = $clog2(UPDATE_GAP + 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
    localparam logic [GAP_W-1:0] GAP_LOAD   = GAP_W'(UPDATE_GAP - 1);

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [GAP_W-1:0] gap;

    logic       push;
    logic       pop;
    logic [7:0] pop_data;
    logic [2:0] target;
    logic [1:0] ch;
    logic       is_atten;
    logic       is_noise;
    logic       is_tone;

    // FIFO handshake and pop qualification.
    assign wr_ready = (count != FULL_COUNT);
    assign push     = wr_valid && wr_ready;
    assign pop      = (count != '0) && (gap == '0);
    assign busy     = (count != '0) || (gap != '0);

    // A data byte (bit7=0) writes to whichever register was latched last.
    assign pop_data = fifo_mem[rd_ptr];
    assign target   = pop_data[7] ? pop_data[6:4] : latch_reg;
    assign ch       = target[2:1];
    assign is_atten = target[0];
    assign is_noise = !target[0] && (ch == 2'd3);
    assign is_tone  = !target[0] && (ch != 2'd3);

    // FIFO storage: writes the incoming byte at the tail.
    // NOTE: data storage has no reset; the reset pointers and count mark every entry invalid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= wr_data;
        end
    end

    // FIFO pointers and occupancy; reset flushes anything queued.
    // NOTE: state is updated with non-blocking assignments so all registers sample the same pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Pacing gap: a tone update blocks further pops for UPDATE_GAP cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gap <= '0;
        end else if (pop && is_tone) begin
            gap <= GAP_LOAD;
        end else if (gap != '0) begin
            gap <= gap - GAP_W'(1);
        end
    end

    // Register decode: applies the popped byte and raises the 1-cycle update pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tone_freq   <= '0;
            atten       <= {4{4'hF}};
            noise_ctrl  <= '0;
            latch_reg   <= '0;
            tone_update <= '0;
            noise_reset <= 1'b0;
        end else begin
            tone_update <= '0;
            noise_reset <= 1'b0;
            if (pop) begin
                if (pop_data[7]) begin
                    latch_reg <= pop_data[6:4];
                end
                if (is_atten) begin
                    atten[ch] <= pop_data[3:0];
                end else if (is_noise) begin
                    noise_ctrl  <= pop_data[2:0];
                    noise_reset <= 1'b1;
                end else begin
                    for (int i = 0; i < 3; i++) begin
                        if (ch == 2'(i)) begin
                            if (pop_data[7]) begin
                                tone_freq[i][3:0] <= pop_data[3:0];
                            end else begin
                                tone_freq[i][9:4] <= pop_data[5:0];
                            end
                            tone_update[i] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

`ifdef PSG_READBACK_EN
    // Combinational readback mux over the architectural registers.
    // NOTE: rd_data gets a default first so no path through the case infers a latch.
    always_comb begin
        rd_data = '0;
        case (rd_addr)
            3'd0:    rd_data = tone_freq[0];
            3'd1:    rd_data = tone_freq[1];
            3'd2:    rd_data = tone_freq[2];
            3'd3:    rd_data = {7'b0, noise_ctrl};
            3'd4:    rd_data = {6'b0, atten[0]};
            3'd5:    rd_data = {6'b0, atten[1]};
            3'd6:    rd_data = {6'b0, atten[2]};
            default: rd_data = {6'b0, atten[3]};
        endcase
    end
`endif

endmodule

// File: tb/tb_psg_reg_file.sv
// tb_psg_reg_file: self-checking bench for psg_reg_file.
// A queue-based behavioural model of the PSG (byte queue, register arrays,
// and "edges since last tone pop" pacing) runs alongside the DUT.
module tb_psg_reg_file;

    localparam int FIFO_DEPTH = 4;
    localparam int UPDATE_GAP = 20;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            wr_valid = 1'b0;
    logic [7:0]      wr_data = 8'h00;
    logic            wr_ready;
    logic [2:0][9:0] tone_freq;
    logic [2:0]      tone_update;
    logic [3:0][3:0] atten;
    logic [2:0]      noise_ctrl;
    logic            noise_reset;
    logic [2:0]      latch_reg;
    logic            busy;
`ifdef PSG_READBACK_EN
    logic [2:0]      rd_addr = 3'd0;
    logic [9:0]      rd_data;
`endif

    int checks = 0;
    int failures = 0;

    psg_reg_file #(.FIFO_DEPTH(FIFO_DEPTH), .UPDATE_GAP(UPDATE_GAP)) dut (
        .clk(clk),
        .reset(reset),
        .wr_valid(wr_valid),
        .wr_data(wr_data),
        .wr_ready(wr_ready),
        .tone_freq(tone_freq),
        .tone_update(tone_update),
        .atten(atten),
        .noise_ctrl(noise_ctrl),
        .noise_reset(noise_reset),
        .latch_reg(latch_reg),
        .busy(busy)
`ifdef PSG_READBACK_EN
        ,
        .rd_addr(rd_addr),
        .rd_data(rd_data)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [7:0]      mq[$];
    logic [2:0][9:0] m_tone;
    logic [3:0][3:0] m_atten;
    logic [2:0]      m_noise;
    logic [2:0]      m_latch;
    logic [2:0]      m_tupd;
    logic            m_nrst;
    int              edge_n = 0;
    int              last_tone_edge = -1000;

    // Pulse monitor (sampled just after each rising edge).
    int tu_cnt[3] = '{0, 0, 0};
    int nr_cnt = 0;
    int last_tu_edge = -1000;
    int min_tu_space = 1000000;

    function automatic void model_reset();
        mq.delete();
        m_tone = '0;
        m_atten = {4{4'hF}};
        m_noise = '0;
        m_latch = '0;
        m_tupd = '0;
        m_nrst = 1'b0;
        last_tone_edge = -1000;
    endfunction

    function automatic void model_apply(input logic [7:0] d);
        int c;
        if (d[7]) m_latch = d[6:4];
        c = int'(m_latch[2:1]);
        if (m_latch[0]) begin
            m_atten[c] = d[3:0];
        end else if (c == 3) begin
            m_noise = d[2:0];
            m_nrst = 1'b1;
        end else begin
            if (d[7]) m_tone[c][3:0] = d[3:0];
            else m_tone[c][9:4] = d[5:0];
            m_tupd[c] = 1'b1;
            last_tone_edge = edge_n;
        end
    endfunction

    // Advance one clock: update the model at the rising edge, return at the falling edge.
    task automatic tick();
        logic [7:0] d;
        bit full_before;
        @(posedge clk);
        edge_n++;
        m_tupd = '0;
        m_nrst = 1'b0;
        if (reset) begin
            model_reset();
        end else begin
            full_before = (mq.size() >= FIFO_DEPTH);
            if (mq.size() != 0 && (edge_n - last_tone_edge) >= UPDATE_GAP) begin
                d = mq.pop_front();
                model_apply(d);
            end
            if (wr_valid && !full_before) mq.push_back(wr_data);
        end
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 3; i++) if (tone_update[i] === 1'b1) tu_cnt[i]++;
        if (|tone_update) begin
            if (edge_n - last_tu_edge < min_tu_space) min_tu_space = edge_n - last_tu_edge;
            last_tu_edge = edge_n;
        end
        if (noise_reset === 1'b1) nr_cnt++;
    end

    // Offer one byte until accepted (bounded); wr_valid drops afterwards.
    task automatic push_byte(input logic [7:0] b);
        bit acc = 1'b0;
        wr_valid = 1'b1;
        wr_data = b;
        for (int i = 0; i < 200 && !acc; i++) begin
            acc = wr_ready;
            tick();
        end
        wr_valid = 1'b0;
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL push_timeout byte %h: wr_ready stayed %b, required 1", b, wr_ready);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_timeout: busy=%b after %0d cycles, required 0", busy, n);
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        model_reset();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        model_reset();
        tick();
        tick();
        checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL rst_ready_in_reset: got %b want 1", wr_ready); end
        checks++; if (atten !== 16'hFFFF) begin failures++; $display("FAIL rst_atten: got %h want ffff", atten); end
        checks++; if (tone_freq !== 30'h0) begin failures++; $display("FAIL rst_tone: got %h want 0", tone_freq); end
        checks++; if (noise_ctrl !== 3'd0 || latch_reg !== 3'd0) begin failures++; $display("FAIL rst_noise_latch: got %h/%h want 0/0", noise_ctrl, latch_reg); end
        checks++; if (tone_update !== 3'b0 || noise_reset !== 1'b0) begin failures++; $display("FAIL rst_pulses: got %b/%b want 0/0", tone_update, noise_reset); end
        reset = 1'b0;
        tick();
        checks++; if (wr_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL rst_ready_busy: got %b/%b want 1/0", wr_ready, busy); end
    endtask

    task automatic test_tone();
        int c0 = tu_cnt[0];
        int first_edge;
        int n = 0;
        push_byte(8'h8E);
        checks++; if (tone_update !== 3'b000) begin failures++; $display("FAIL tone_no_bypass: got %b want 000", tone_update); end
        push_byte(8'h0F);
        checks++; if (tone_update !== 3'b001 || tone_freq[0] !== 10'h00E) begin failures++; $display("FAIL tone_latch_apply: got upd=%b freq=%h want 001/00e", tone_update, tone_freq[0]); end
        first_edge = last_tu_edge;
        while (tu_cnt[0] < c0 + 2 && n < 60) begin tick(); n++; end
        checks++; if (last_tu_edge - first_edge !== UPDATE_GAP) begin failures++; $display("FAIL tone_gap: got %0d cycles want %0d", last_tu_edge - first_edge, UPDATE_GAP); end
        wait_idle(60);
        checks++; if (tone_freq[0] !== 10'h0FE) begin failures++; $display("FAIL tone_final: got %h want 0fe", tone_freq[0]); end
        checks++; if (tu_cnt[0] !== c0 + 2) begin failures++; $display("FAIL tone_pulse_count: got %0d want %0d", tu_cnt[0] - c0, 2); end
    endtask

    task automatic test_atten();
        int t0 = tu_cnt[0] + tu_cnt[1] + tu_cnt[2];
        push_byte(8'hD5);
        push_byte(8'h9A);
        checks++; if (latch_reg !== 3'b101 || atten[2] !== 4'h5) begin failures++; $display("FAIL atten_d5: got latch=%b atten2=%h want 101/5", latch_reg, atten[2]); end
        tick();
        checks++; if (atten[0] !== 4'hA || latch_reg !== 3'b001) begin failures++; $display("FAIL atten_next_pop: got atten0=%h latch=%b want a/001", atten[0], latch_reg); end
        checks++; if (tu_cnt[0] + tu_cnt[1] + tu_cnt[2] !== t0 || busy !== 1'b0) begin failures++; $display("FAIL atten_no_tone: got pulses=%0d busy=%b want 0/0", tu_cnt[0] + tu_cnt[1] + tu_cnt[2] - t0, busy); end
    endtask

    task automatic test_noise();
        int n0 = nr_cnt;
        push_byte(8'hE4);
        push_byte(8'h03);
        checks++; if (noise_ctrl !== 3'd4 || noise_reset !== 1'b1) begin failures++; $display("FAIL noise_latch: got ctrl=%0d rst=%b want 4/1", noise_ctrl, noise_reset); end
        tick();
        checks++; if (noise_ctrl !== 3'd3 || noise_reset !== 1'b1) begin failures++; $display("FAIL noise_data: got ctrl=%0d rst=%b want 3/1", noise_ctrl, noise_reset); end
        tick();
        checks++; if (noise_reset !== 1'b0 || busy !== 1'b0 || nr_cnt !== n0 + 2) begin failures++; $display("FAIL noise_end: got rst=%b busy=%b pulses=%0d want 0/0/2", noise_reset, busy, nr_cnt - n0); end
    endtask

    task automatic test_burst();
        logic [7:0] bytes_q[$] = '{8'h80, 8'h81, 8'h82, 8'hA0, 8'hA1, 8'hC0};
        int c[3];
        int drop_idx = -1;
        pulse_reset();
        for (int i = 0; i < 3; i++) c[i] = tu_cnt[i];
        last_tu_edge = -1000;
        min_tu_space = 1000000;
        wr_valid = 1'b1;
        foreach (bytes_q[k]) begin
            bit acc = 1'b0;
            wr_data = bytes_q[k];
            for (int i = 0; i < 200 && !acc; i++) begin
                acc = wr_ready;
                if (!acc && drop_idx < 0) drop_idx = k;
                tick();
            end
        end
        wr_valid = 1'b0;
        checks++; if (drop_idx !== 5) begin failures++; $display("FAIL burst_ready_drop: got byte index %0d want 5", drop_idx); end
        wait_idle(300);
        checks++; if (tone_freq !== {10'h000, 10'h001, 10'h002}) begin failures++; $display("FAIL burst_tone: got %h want %h", tone_freq, {10'h000, 10'h001, 10'h002}); end
        checks++; if (tu_cnt[0] - c[0] !== 3 || tu_cnt[1] - c[1] !== 2 || tu_cnt[2] - c[2] !== 1) begin failures++; $display("FAIL burst_pulses: got %0d/%0d/%0d want 3/2/1", tu_cnt[0] - c[0], tu_cnt[1] - c[1], tu_cnt[2] - c[2]); end
        checks++; if (min_tu_space !== UPDATE_GAP) begin failures++; $display("FAIL burst_spacing: got %0d want %0d", min_tu_space, UPDATE_GAP); end
        checks++; if (latch_reg !== 3'b100 || wr_ready !== 1'b1) begin failures++; $display("FAIL burst_end: got latch=%b ready=%b want 100/1", latch_reg, wr_ready); end
    endtask

    task automatic test_reset_flush();
        int t0;
        push_byte(8'h85);
        push_byte(8'h93);
        push_byte(8'hB3);
        push_byte(8'hD3);
        checks++; if (tone_freq[0] !== 10'h005 || busy !== 1'b1) begin failures++; $display("FAIL flush_setup: got freq0=%h busy=%b want 005/1", tone_freq[0], busy); end
        reset = 1'b1;
        model_reset();
        #1;
        checks++; if (busy !== 1'b0 || wr_ready !== 1'b1 || tone_freq !== 30'h0 || atten !== 16'hFFFF) begin failures++; $display("FAIL flush_async: got busy=%b ready=%b tone=%h atten=%h want 0/1/0/ffff", busy, wr_ready, tone_freq, atten); end
        @(negedge clk);
        tick();
        reset = 1'b0;
        t0 = tu_cnt[0];
        for (int i = 0; i < 40; i++) tick();
        checks++; if (atten !== 16'hFFFF || tone_freq !== 30'h0 || busy !== 1'b0 || tu_cnt[0] !== t0) begin failures++; $display("FAIL flush_never_applied: got atten=%h tone=%h busy=%b want ffff/0/0", atten, tone_freq, busy); end
    endtask

    task automatic test_random();
        logic exp_busy;
        pulse_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            wr_valid = (cyc < 1300) && ($urandom_range(0, 2) == 0);
            wr_data = 8'($urandom);
            tick();
            exp_busy = (mq.size() != 0) || ((edge_n - last_tone_edge) < UPDATE_GAP - 1);
            checks++; if (tone_freq !== m_tone) begin failures++; $display("FAIL rnd_tone cyc %0d: got %h want %h", cyc, tone_freq, m_tone); end
            checks++; if (atten !== m_atten) begin failures++; $display("FAIL rnd_atten cyc %0d: got %h want %h", cyc, atten, m_atten); end
            checks++; if (noise_ctrl !== m_noise || latch_reg !== m_latch) begin failures++; $display("FAIL rnd_noise_latch cyc %0d: got %h/%h want %h/%h", cyc, noise_ctrl, latch_reg, m_noise, m_latch); end
            checks++; if (tone_update !== m_tupd || noise_reset !== m_nrst) begin failures++; $display("FAIL rnd_pulses cyc %0d: got %b/%b want %b/%b", cyc, tone_update, noise_reset, m_tupd, m_nrst); end
            checks++; if (wr_ready !== (mq.size() < FIFO_DEPTH) || busy !== exp_busy) begin failures++; $display("FAIL rnd_ready_busy cyc %0d: got %b/%b want %b/%b", cyc, wr_ready, busy, mq.size() < FIFO_DEPTH, exp_busy); end
        end
        wr_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_tone();
        test_atten();
        test_noise();
        test_burst();
        test_reset_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

endmodule
